// File: rtl/seg7_scan_if.sv
// Bundle for the multiplexed 7-segment display bus and the decoded frame outputs.
// The display side drives segments and enables; the decoder drives frame results back.
interface seg7_scan_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] value;
    logic              value_ok;
    logic              frame_valid;
    logic              code_err;
    logic              stale;

    modport master (
        output seg,
        output an,
        input  value,
        input  value_ok,
        input  frame_valid,
        input  code_err,
        input  stale
    );

    modport slave (
        input  seg,
        input  an,
        output value,
        output value_ok,
        output frame_valid,
        output code_err,
        output stale
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches a scanned active-low 7-segment bus, debounces each digit dwell, decodes it
// back to a hex nibble and publishes a complete multi-digit frame.
module seg7_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0]   CNT_ARM  = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WW-1:0]   WD_MAX   = WW'(TIMEOUT);
    localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0]   WD_ONE   = WW'(1);
    localparam logic [NDIG-1:0] DIG_ONE  = NDIG'(1);
    localparam logic [NDIG-1:0] ALL_SEEN = '1;

    // Bit 4 flags a legal pattern; bits 3:0 carry the decoded nibble.
    function automatic logic [4:0] decode7(input logic [6:0] s);
        logic [4:0] d;
        case (s)
            7'h40:   d = 5'h10;
            7'h79:   d = 5'h11;
            7'h24:   d = 5'h12;
            7'h30:   d = 5'h13;
            7'h19:   d = 5'h14;
            7'h12:   d = 5'h15;
            7'h02:   d = 5'h16;
            7'h78:   d = 5'h17;
            7'h00:   d = 5'h18;
            7'h18:   d = 5'h19;
            7'h08:   d = 5'h1A;
            7'h03:   d = 5'h1B;
            7'h27:   d = 5'h1C;
            7'h21:   d = 5'h1D;
            7'h06:   d = 5'h1E;
            7'h0E:   d = 5'h1F;
            default: d = 5'h00;
        endcase
        return d;
    endfunction

    logic [6:0]        seg_r;
    logic [NDIG-1:0]   an_r;
    logic [6:0]        seg_prev_r;
    logic [NDIG-1:0]   an_prev_r;
    logic [CW-1:0]     cnt_r;
    logic [WW-1:0]     wd_r;
    logic [4*NDIG-1:0] store_r;
    logic [NDIG-1:0]   ok_r;
    logic [NDIG-1:0]   seen_r;
    logic [4*NDIG-1:0] value_r;
    logic              value_ok_r;
    logic              frame_valid_r;
    logic              code_err_r;
    logic              stale_r;

    logic [NDIG-1:0]   en_s;
    logic              onehot_s;
    logic              same_s;
    logic              accept_s;
    logic [CW-1:0]     cnt_nxt_s;
    logic [4:0]        dec_s;
    logic              frame_s;
    logic              timeout_s;
    logic [WW-1:0]     wd_nxt_s;
    logic [4*NDIG-1:0] store_nxt_s;
    logic [NDIG-1:0]   ok_nxt_s;
    logic [NDIG-1:0]   seen_nxt_s;

    // Dwell tracking: the count holds how many identical samples the previous cycle had seen.
    always_comb begin
        en_s      = ~an_r;
        onehot_s  = (en_s != '0) && ((en_s & (en_s - DIG_ONE)) == '0);
        same_s    = (seg_r == seg_prev_r) && (an_r == an_prev_r);
        dec_s     = decode7(seg_r);
        cnt_nxt_s = '0;
        accept_s  = 1'b0;
        if (!onehot_s) begin
            cnt_nxt_s = '0;
            accept_s  = 1'b0;
        end else if (!same_s) begin
            cnt_nxt_s = (STABLE_CYC == 1) ? CNT_MAX : CNT_ONE;
            accept_s  = (STABLE_CYC == 1);
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = cnt_r;
            accept_s  = 1'b0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            accept_s  = (cnt_r == CNT_ARM);
        end
    end

    // Frame assembly, watchdog and per-digit store updates; an accept beats a timeout.
    always_comb begin
        frame_s     = (seen_r == ALL_SEEN);
        timeout_s   = (!accept_s) && (wd_r == WD_LAST);
        store_nxt_s = store_r;
        ok_nxt_s    = ok_r;
        seen_nxt_s  = seen_r;
        wd_nxt_s    = wd_r;
        if (accept_s) begin
            wd_nxt_s = '0;
        end else if (wd_r == WD_MAX) begin
            wd_nxt_s = wd_r;
        end else begin
            wd_nxt_s = wd_r + WD_ONE;
        end
        for (int i = 0; i < NDIG; i++) begin
            if (accept_s && en_s[i]) begin
                seen_nxt_s[i]      = 1'b1;
                ok_nxt_s[i]        = dec_s[4];
                store_nxt_s[4*i +: 4] = dec_s[4] ? dec_s[3:0] : store_r[4*i +: 4];
            end else begin
                seen_nxt_s[i]      = (frame_s || timeout_s) ? 1'b0 : seen_r[i];
                ok_nxt_s[i]        = timeout_s ? 1'b0 : ok_r[i];
                store_nxt_s[4*i +: 4] = store_r[4*i +: 4];
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r         <= 7'h00;
            an_r          <= '0;
            seg_prev_r    <= 7'h00;
            an_prev_r     <= '0;
            cnt_r         <= '0;
            wd_r          <= '0;
            store_r       <= '0;
            ok_r          <= '0;
            seen_r        <= '0;
            value_r       <= '0;
            value_ok_r    <= 1'b0;
            frame_valid_r <= 1'b0;
            code_err_r    <= 1'b0;
            stale_r       <= 1'b0;
        end else begin
            seg_r         <= bus.seg;
            an_r          <= bus.an;
            seg_prev_r    <= seg_r;
            an_prev_r     <= an_r;
            cnt_r         <= cnt_nxt_s;
            wd_r          <= wd_nxt_s;
            store_r       <= store_nxt_s;
            ok_r          <= ok_nxt_s;
            seen_r        <= seen_nxt_s;
            frame_valid_r <= frame_s;
            code_err_r    <= accept_s && !dec_s[4];
            stale_r       <= timeout_s;
            if (frame_s) begin
                value_r    <= store_r;
                value_ok_r <= &ok_r;
            end else begin
                value_r    <= value_r;
                value_ok_r <= value_ok_r;
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.value_ok    = value_ok_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.code_err    = code_err_r;
    assign bus.stale       = stale_r;

endmodule
